// File: rtl/rx_xgmii_pack.sv
// Packs 32-bit XGMII words into 64-bit words, with /S/ forced into lane 0.
// Define RX_PACK_REALIGN_CNT_EN to build the realignment counter.
module rx_xgmii_pack #(
  parameter logic [7:0] START_CHAR = 8'hDF,
  parameter logic [7:0] IDLE_CHAR  = 8'hE0,
  parameter logic [7:0] ERROR_CHAR = 8'h7F,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             rxclk_2x,
  input  logic             reset_out,
  input  logic [31:0]      rxd_in,
  input  logic [3:0]       rxc_in,
  output logic [63:0]      rxd64,
  output logic [7:0]       rxc8,
  output logic             rxd64_valid,
  output logic             align_err,
  output logic [CNT_W-1:0] realign_cnt
);

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } phase_t;

  phase_t      phase;
  logic [31:0] lo_d;
  logic [3:0]  lo_c;
  logic [31:0] wd;
  logic [3:0]  mis;
  logic        start;
  logic        realign;

  // a /S/ outside lane 0 can never be framed correctly; poison it
  always_comb begin
    wd  = rxd_in;
    mis = '0;
    for (int n = 1; n < 4; n++) begin
      if (rxc_in[n] && (rxd_in[8*n +: 8] == START_CHAR)) begin
        mis[n]         = 1'b1;
        wd[8*n +: 8]   = ERROR_CHAR;
      end
    end
  end

  assign start   = rxc_in[0] && (rxd_in[7:0] == START_CHAR);
  assign realign = (phase == HI) && start;

  always_ff @(posedge rxclk_2x or posedge reset_out) begin
    if (reset_out) begin
      phase       <= LO;
      lo_d        <= {4{IDLE_CHAR}};
      lo_c        <= 4'hF;
      rxd64       <= {8{IDLE_CHAR}};
      rxc8        <= 8'hFF;
      rxd64_valid <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      align_err   <= |mis;
      rxd64_valid <= 1'b0;
      unique case (phase)
        LO: begin
          lo_d  <= wd;
          lo_c  <= rxc_in;
          phase <= HI;
        end
        HI: begin
          rxd64_valid <= 1'b1;
          if (start) begin
            // flush the orphan half, start word becomes new low half
            rxd64 <= {{4{IDLE_CHAR}}, lo_d};
            rxc8  <= {4'hF, lo_c};
            lo_d  <= wd;
            lo_c  <= rxc_in;
            phase <= HI;
          end else begin
            rxd64 <= {wd, lo_d};
            rxc8  <= {rxc_in, lo_c};
            phase <= LO;
          end
        end
        default: phase <= LO;
      endcase
    end
  end

`ifdef RX_PACK_REALIGN_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge rxclk_2x or posedge reset_out) begin
    if (reset_out) begin
      cnt <= '0;
    end else if (realign && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign realign_cnt = cnt;
`else
  logic unused_realign;

  assign unused_realign = realign;
  assign realign_cnt    = '0;
`endif

endmodule

// File: tb/tb_rx_xgmii_pack.sv
// Scoreboard bench for rx_xgmii_pack (CNT_W = 4).
// Expected words are queued by the stimulus; a negedge monitor checks them.
module tb_rx_xgmii_pack;

  localparam logic [31:0] IDLE = 32'hE0E0E0E0;
  localparam logic [31:0] SW   = 32'h555555DF;
  localparam logic [31:0] DW   = 32'hD5555555;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
  } exp_t;

  logic        rxclk_2x = 1'b0;
  logic        reset_out = 1'b1;
  logic [31:0] rxd_in = IDLE;
  logic [3:0]  rxc_in = 4'hF;
  logic [63:0] rxd64;
  logic [7:0]  rxc8;
  logic        rxd64_valid;
  logic        align_err;
  logic [3:0]  realign_cnt;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   err_cnt = 0;
  int   b2b = 0;
  int   b0;
  logic prev_v = 1'b0;

  rx_xgmii_pack #(.CNT_W(4)) dut (
    .rxclk_2x    (rxclk_2x),
    .reset_out   (reset_out),
    .rxd_in      (rxd_in),
    .rxc_in      (rxc_in),
    .rxd64       (rxd64),
    .rxc8        (rxc8),
    .rxd64_valid (rxd64_valid),
    .align_err   (align_err),
    .realign_cnt (realign_cnt)
  );

  always #5 rxclk_2x = ~rxclk_2x;

  function automatic logic [3:0] exp_cnt(input int n);
`ifdef RX_PACK_REALIGN_CNT_EN
    return (n > 15) ? 4'hF : 4'(n);
`else
    return 4'h0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] c);
    @(negedge rxclk_2x);
    rxd_in = d;
    rxc_in = c;
  endtask

  task automatic pair(input logic [31:0] d0, input logic [3:0] c0,
                      input logic [31:0] d1, input logic [3:0] c1,
                      input logic [63:0] ed, input logic [7:0] ec);
    push(ed, ec);
    send(d0, c0);
    send(d1, c1);
  endtask

  task automatic idle_pair();
    pair(IDLE, 4'hF, IDLE, 4'hF, {2{IDLE}}, 8'hFF);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rxd64"}, rxd64, {2{IDLE}});
    chk({tag, "_rxc8"}, 64'(rxc8), 64'hFF);
    chk({tag, "_valid"}, 64'(rxd64_valid), 64'h0);
    chk({tag, "_align_err"}, 64'(align_err), 64'h0);
    chk({tag, "_cnt"}, 64'(realign_cnt), 64'h0);
  endtask

  always @(negedge rxclk_2x) begin
    if (!reset_out) begin
      if (rxd64_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got %h/%h expected none",
                   rxd64, rxc8);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_d", rxd64, e.d);
          chk("word_c", 64'(rxc8), 64'(e.c));
        end
      end
      if (prev_v && rxd64_valid) b2b++;
      if (align_err) err_cnt++;
      prev_v = rxd64_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    repeat (3) @(negedge rxclk_2x);
    chk_reset("rst");
    @(posedge rxclk_2x);
    #1 reset_out = 1'b0;

    // aligned start
    idle_pair();
    pair(SW, 4'h1, DW, 4'h0, {DW, SW}, 8'h01);
    idle_pair();
    chk("aligned_cnt", 64'(realign_cnt), 64'(exp_cnt(0)));

    // misaligned start: one idle then start in HI
    push({2{IDLE}}, 8'hFF);
    push({DW, SW}, 8'h01);
    send(IDLE, 4'hF);
    send(SW, 4'h1);
    send(DW, 4'h0);
    idle_pair();
    chk("misalign_cnt", 64'(realign_cnt), 64'(exp_cnt(1)));

    // misplaced /S/ in lane 2 then lane 3
    pair(32'h55DF5555, 4'h4, 32'h12345678, 4'h0,
         64'h12345678_557F5555, 8'h04);
    pair(32'hAABBCCDD, 4'h0, 32'hDF112233, 4'h8,
         64'h7F112233_AABBCCDD, 8'h80);
    idle_pair();
    chk("misplaced_err_pulses", 64'(err_cnt), 64'd2);
    chk("misplaced_cnt", 64'(realign_cnt), 64'(exp_cnt(1)));

    // 20 forced realigns: counter saturates
    send(IDLE, 4'hF);
    for (int i = 0; i < 20; i++) begin
      if (i == 0) push({2{IDLE}}, 8'hFF);
      else push({IDLE, SW}, 8'hF1);
      send(SW, 4'h1);
      if (i == 10) chk("sat_mid_cnt", 64'(realign_cnt), 64'(exp_cnt(11)));
    end
    push({DW, SW}, 8'h01);
    send(DW, 4'h0);
    idle_pair();
    chk("sat_cnt", 64'(realign_cnt), 64'(exp_cnt(21)));
    chk("sat_no_err", 64'(err_cnt), 64'd2);

    // reset while HI holding a start word
    send(SW, 4'h1);
    @(posedge rxclk_2x);
    #2 reset_out = 1'b1;
    rxd_in = IDLE;
    rxc_in = 4'hF;
    #1 chk_reset("midrst");
    repeat (3) @(posedge rxclk_2x);
    #1 reset_out = 1'b0;
    pair(32'hAAAAAAAA, 4'h0, 32'hBBBBBBBB, 4'h0,
         64'hBBBBBBBB_AAAAAAAA, 8'h00);
    idle_pair();

    // continuous traffic after aligned start
    b0 = b2b;
    pair(SW, 4'h1, DW, 4'h0, {DW, SW}, 8'h01);
    for (int i = 0; i < 48; i++) begin
      logic [31:0] w0, w1;
      w0 = 32'h10203040 + 32'(2*i) * 32'h01010101;
      w1 = 32'h10203040 + 32'(2*i+1) * 32'h01010101;
      pair(w0, 4'h0, w1, 4'h0, {w1, w0}, 8'h00);
    end
    idle_pair();
    chk("stream_no_b2b", 64'(b2b), 64'(b0));

    @(negedge rxclk_2x);
    @(negedge rxclk_2x);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
